// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches into a prefetch queue, pairs in-order
// responses with their PCs, and flushes on redirect. Define FETCH_QUEUE_BYPASS_EN for rsp->inst bypass.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [XLEN-1:0]            imem_req_addr,
   input  logic                       imem_rsp_valid,
   input  logic [31:0]                imem_rsp_data,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       inst_valid,
   input  logic                       inst_ready,
   output logic [31:0]                inst_data,
   output logic [XLEN-1:0]            inst_pc,
   output logic [$clog2(DEPTH+1)-1:0] fq_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  slot_pc   [DEPTH];
   logic [31:0]      slot_data [DEPTH];
   logic [DEPTH-1:0] slot_filled;
   logic [PW-1:0]    head, tail, fill;
   // pend counts allocated slots still waiting for their response
   logic [CW-1:0]    alloc, drop, pend;
   logic [CW:0]      credit_used;
   logic             issue, pop, rsp_drop, rsp_take;

   assign credit_used    = {1'b0, alloc} + {1'b0, drop};
   assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign issue          = imem_req_valid && imem_req_ready;
   assign rsp_drop       = imem_rsp_valid && (drop != '0);
   assign rsp_take       = imem_rsp_valid && (drop == '0) && (pend != '0);
   assign inst_pc        = slot_pc[head];
   assign fq_count       = alloc;

`ifdef FETCH_QUEUE_BYPASS_EN
   // An unfilled head is always the oldest pending slot, so a taken response belongs to it
   logic bypass_hit;
   assign bypass_hit = rsp_take && !slot_filled[head];
   assign inst_valid = (slot_filled[head] || bypass_hit) && !redirect_valid;
   assign inst_data  = bypass_hit ? imem_rsp_data : slot_data[head];
`else
   assign inst_valid = slot_filled[head] && !redirect_valid;
   assign inst_data  = slot_data[head];
`endif

   assign pop = inst_valid && inst_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         head        <= '0;
         tail        <= '0;
         fill        <= '0;
         alloc       <= '0;
         drop        <= '0;
         pend        <= '0;
         slot_filled <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_pc[i]   <= '0;
            slot_data[i] <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_pc & ~XLEN'(3);
         head        <= tail;
         fill        <= tail;
         alloc       <= '0;
         pend        <= '0;
         slot_filled <= '0;
         // Everything still in flight, minus whatever response arrives right now, is stale
         drop        <= drop + pend - CW'(rsp_drop || rsp_take);
      end else begin
         if (issue) begin
            slot_pc[tail] <= fetch_pc;
            tail          <= tail + 1'b1;
            fetch_pc      <= fetch_pc + XLEN'(4);
         end
         if (rsp_drop)
            drop <= drop - 1'b1;
         if (rsp_take) begin
            slot_data[fill]   <= imem_rsp_data;
            slot_filled[fill] <= 1'b1;
            fill              <= fill + 1'b1;
         end
         // Placed after the fill so a bypassed, same-cycle pop leaves the slot released
         if (pop) begin
            slot_filled[head] <= 1'b0;
            head              <= head + 1'b1;
         end
         alloc <= alloc + CW'(issue) - CW'(pop);
         pend  <= pend + CW'(issue) - CW'(rsp_take);
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a queue-based reference model of PCs in flight, ready entries
// and drop credits, driven by an in-order memory model with random latency.
module tb_fetch_queue;
   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid, inst_ready = 1'b0;
   logic [31:0] inst_data, inst_pc;
   logic [2:0]  fq_count;

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .fq_count(fq_count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
   typedef struct { logic [31:0] data; int due; } mrsp_t;

   logic [31:0] m_pc;
   int          m_drop;
   logic [31:0] m_pend[$];
   ent_t        m_rdy[$];
   mrsp_t       mem_q[$];
   int          cyc;

   int p_rdy, p_inst, p_redir, lat_min, lat_max;
   logic        force_redir = 1'b0;
   logic [31:0] force_pc = '0;

   int nchk = 0, nerr = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_fq_count", fq_count, 0);
      repeat (2) @(posedge clk);
      m_pc = RESET_PC; m_drop = 0;
      m_pend.delete(); m_rdy.delete(); mem_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("first_req_valid", imem_req_valid, 1);
      chk("first_req_addr", imem_req_addr, RESET_PC);
   endtask

   task automatic step();
      logic        rsp, was, evq, evi, byp;
      logic [31:0] rdata;
      ent_t        e;
      mrsp_t       r;
      @(negedge clk);
      imem_req_ready = ($urandom_range(99) < p_rdy);
      inst_ready     = ($urandom_range(99) < p_inst);
      was = redirect_valid;
      redirect_valid = 1'b0;
      if (force_redir) begin
         redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
      end else if (!was && $urandom_range(99) < p_redir) begin
         redirect_valid = 1'b1;
         redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom;
      end
      rsp   = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      rdata = rsp ? mem_q[0].data : $urandom;
      imem_rsp_valid = rsp;
      imem_rsp_data  = rdata;
      #1;
      evq = !redirect_valid && (m_pend.size() + m_rdy.size() + m_drop < DEPTH);
      byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = rsp && (m_drop == 0) && (m_rdy.size() == 0) && (m_pend.size() > 0);
`endif
      evi = !redirect_valid && ((m_rdy.size() > 0) || byp);
      chk("req_valid", imem_req_valid, evq);
      chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", inst_valid, evi);
      if (evi) begin
         chk("inst_pc", inst_pc, byp ? m_pend[0] : m_rdy[0].pc);
         chk("inst_data", inst_data, byp ? rdata : m_rdy[0].data);
      end
      chk("fq_count", fq_count, m_pend.size() + m_rdy.size());
      @(posedge clk);
      cyc++;
      if (rsp) void'(mem_q.pop_front());
      if (redirect_valid) begin
         if (rsp) begin
            if (m_drop > 0) m_drop--;
            else if (m_pend.size() > 0) void'(m_pend.pop_front());
         end
         m_drop += m_pend.size();
         m_pend.delete(); m_rdy.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (rsp) begin
            if (m_drop > 0) m_drop--;
            else if (m_pend.size() > 0) begin
               e.pc = m_pend.pop_front(); e.data = rdata; m_rdy.push_back(e);
            end
         end
         if (evi && inst_ready) void'(m_rdy.pop_front());
         if (evq && imem_req_ready) begin
            m_pend.push_back(m_pc);
            r.data = $urandom;
            r.due  = cyc - 1 + $urandom_range(lat_max, lat_min);
            mem_q.push_back(r);
            m_pc += 32'd4;
         end
      end
   endtask

   task automatic phase(input int n, input int rdy, input int inst, input int redir, input int lmin, input int lmax);
      p_rdy = rdy; p_inst = inst; p_redir = redir; lat_min = lmin; lat_max = lmax;
      repeat (n) step();
   endtask

   initial begin
      cyc = 0; m_pc = RESET_PC; m_drop = 0;
      do_reset();
      // Streaming, single-cycle memory, decode always ready
      phase(20, 100, 100, 0, 1, 1);
      // Decode stalled: queue fills, then single-cycle drains
      phase(10, 100, 0, 0, 1, 1);
      phase(1, 100, 100, 0, 1, 1);
      phase(4, 100, 0, 0, 1, 1);
      // Slow memory, redirect to an unaligned target with responses in flight
      phase(6, 100, 100, 0, 3, 3);
      force_redir = 1'b1; force_pc = 32'h0000_0103;
      phase(20, 100, 100, 0, 3, 3);
      // Redirect near the top of the address space with a stuttering request port
      force_redir = 1'b1; force_pc = 32'hFFFF_FFF4;
      phase(30, 50, 70, 0, 1, 2);
      // Mixed random traffic with a reset in the middle
      phase(1500, 70, 60, 5, 1, 4);
      do_reset();
      phase(1500, 80, 80, 3, 1, 3);
      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end with a prefetch queue, sitting between the PC/redirect logic and a handshaked instruction memory. It issues sequential word fetches ahead of decode, pairs each in-order memory response with the PC that requested it, and presents instructions to decode over a valid/ready interface. It flushes cleanly on redirect, discarding responses still in flight from the abandoned path.

## Interface
- `XLEN`, default 32: address/PC width.
- `DEPTH`, default 4: queue slots; power of two, ≥2.
- `RESET_PC`, default 0: first fetch address after reset; word aligned.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts request.
- `imem_req_addr` output XLEN: fetch address, bits [1:0] always 0.
- `imem_rsp_valid` input 1: response valid; in order, one per accepted request, never back-pressured.
- `imem_rsp_data` input 32: fetched instruction word.
- `redirect_valid` input 1: branch/jump redirect, single-cycle pulse.
- `redirect_pc` input XLEN: redirect target; bits [1:0] ignored.
- `inst_valid` output 1: head instruction available.
- `inst_ready` input 1: decode accepts head.
- `inst_data` output 32: head instruction.
- `inst_pc` output XLEN: PC of head instruction.
- `fq_count` output $clog2(DEPTH+1): allocated slots (filled + awaiting response).

## Operation
- State: `fetch_pc`; slot array {pc, data, filled}; head/tail/fill pointers (log2 DEPTH bits, wrap modulo DEPTH); `alloc` count (0..DEPTH); `drop` count (0..DEPTH).
- Issue: `imem_req_valid = !redirect_valid && (alloc + drop < DEPTH)`; `imem_req_addr = fetch_pc`. On req handshake: write `fetch_pc` into slot[tail], filled=0, tail++, alloc++, `fetch_pc += 4` (wraps modulo 2^XLEN).
- Response, `drop > 0`: discarded, drop−−. Otherwise: data → slot[fill], filled=1, fill++.
- Output: `inst_valid = slot[head].filled && !redirect_valid`; data/pc from slot[head]. On handshake: head++, alloc−−.
- Simultaneous allocate and pop: alloc unchanged; issue eligibility uses the pre-pop count, so no same-cycle slot reuse.
- Redirect: all slots invalidated, head=tail=fill; alloc=0; `fetch_pc = {redirect_pc[XLEN-1:2],2'b00}`. Drop loads drop + (unfilled allocated slots) − `imem_rsp_valid`; any response in the redirect cycle is discarded. No request and no pop occur in the redirect cycle.
- Response with no outstanding request: protocol violation; ignored, counters unchanged.

## Timing
- Reset (asynchronous assert, synchronous release): fetch_pc=RESET_PC, pointers/alloc/drop=0, all slots cleared; `imem_req_valid`=0 during reset, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `fq_count`=0.
- First clock after release: `imem_req_valid`=1, addr=RESET_PC.
- Issue throughput: one request per cycle while credits remain.
- Response at cycle N → `inst_valid` at N+1 (registered), unless bypass is enabled.
- Redirect at N → first new-path request at N+1 (addr = target).
- Full: alloc+drop == DEPTH stalls issue until a pop or dropped response frees a credit (visible the next cycle).
- Reset mid-operation: all state cleared immediately; in-flight responses are the memory's responsibility to squash.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when the head slot is unfilled and a non-dropped response arrives for it, `inst_valid`=1 in the same cycle with `inst_data=imem_rsp_data`. If popped that cycle, the slot is released without being written. Response-to-issue latency is 0.
- Not defined: no combinational path from `imem_rsp_*` to `inst_*`; latency 1.

## Test plan
- Reset release, `imem_req_ready`=1, response latency 1, `inst_ready`=1 → addrs 0x0,0x4,0x8… one per cycle; `inst_pc` 0x0,0x4… with matching data; steady 1 instr/cycle.
- `inst_ready`=0, DEPTH=4 → exactly 4 requests issued, `fq_count`=4, `imem_req_valid`=0; raising `inst_ready` for one cycle → one new request on the following cycle.
- Response latency 3, redirect to 0x103 with 2 responses outstanding → next request addr 0x100; the 2 stale responses are discarded; first `inst_pc`=0x100.
- Redirect coincident with `imem_rsp_valid` and 1 outstanding → that response is dropped, drop ends at 0, next accepted data pairs with 0x100.
- `imem_req_ready` toggling 1,0,1 with `fetch_pc`=0xFFFFFFFC (XLEN=32) → addr held stable while stalled; next address wraps to 0x0.
- With `FETCH_QUEUE_BYPASS_EN`, empty queue, response 0x00500093 → `inst_valid`=1 and `inst_data`=0x00500093 in the same cycle; without it, on the next cycle.
